// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU instructions into an execute register that
// drives a combinational ALU, then captures the ALU result into a writeback register.
// Both registers use valid/ready handshakes, so the pipeline sustains one op per cycle.
module alu_issue_stage #(
   parameter int unsigned XLen = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLen-1:0] rs1_data_i,
   input  logic [XLen-1:0] rs2_data_i,
   output logic [XLen-1:0] alu_a_o,
   output logic [XLen-1:0] alu_b_o,
   output logic [2:0]      alu_control_o,
   input  logic [XLen-1:0] alu_result_i,
   input  logic            alu_zero_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLen-1:0] out_result_o,
   output logic            out_zero_o,
   output logic [4:0]      out_rd_o,
   output logic            out_illegal_o
);

   localparam logic [6:0] OpReg = 7'b0110011;
   localparam logic [6:0] OpImm = 7'b0010011;

   // Execute register
   logic            r_e_valid;
   logic [XLen-1:0] r_e_a;
   logic [XLen-1:0] r_e_b;
   logic [2:0]      r_e_ctrl;
   logic [4:0]      r_e_rd;
   logic            r_e_illegal;

   // Writeback register
   logic            r_w_valid;
   logic [XLen-1:0] r_w_result;
   logic            r_w_zero;
   logic [4:0]      r_w_rd;
   logic            r_w_illegal;

   logic            w_is_r;
   logic            w_is_i;
   logic            w_legal;
   logic [2:0]      w_ctrl;
   logic [XLen-1:0] w_imm;
   logic [XLen-1:0] w_a;
   logic [XLen-1:0] w_b;
   logic            w_advance;
   logic            w_transfer;
   logic            w_accept;
   logic            w_unused;

   // The rs1 specifier field is resolved upstream; only its data is used here.
   assign w_unused = ^instr_i[19:15];

   assign w_is_r = (instr_i[6:0] == OpReg);
   assign w_is_i = (instr_i[6:0] == OpImm);
   assign w_imm  = {{(XLen-12){instr_i[31]}}, instr_i[31:20]};

   // Decode opcode/funct3 into the ALU control code; unsupported ops map to 111.
   always_comb begin
      w_ctrl  = 3'b111;
      w_legal = 1'b0;
      if (w_is_r || w_is_i) begin
         w_legal = 1'b1;
         case (instr_i[14:12])
            3'b000:  w_ctrl = (w_is_r && instr_i[30]) ? 3'b001 : 3'b000;
            3'b010:  w_ctrl = 3'b101;
            3'b110:  w_ctrl = 3'b011;
            3'b111:  w_ctrl = 3'b010;
            default: begin
               w_ctrl  = 3'b111;
               w_legal = 1'b0;
            end
         endcase
      end
   end

   assign w_a = w_legal ? rs1_data_i : '0;
   assign w_b = !w_legal ? '0 : (w_is_r ? rs2_data_i : w_imm);

   assign w_advance  = ~r_w_valid | out_ready_i;
   assign w_transfer = r_e_valid & w_advance;
   assign in_ready_o = ~r_e_valid | w_advance;
   assign w_accept   = in_valid_i & in_ready_o;

   // Execute register: load on accept, empty when its content moves on without a refill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_e_valid   <= 1'b0;
         r_e_a       <= '0;
         r_e_b       <= '0;
         r_e_ctrl    <= 3'b000;
         r_e_rd      <= 5'd0;
         r_e_illegal <= 1'b0;
      end else if (w_accept) begin
         r_e_valid   <= 1'b1;
         r_e_a       <= w_a;
         r_e_b       <= w_b;
         r_e_ctrl    <= w_ctrl;
         r_e_rd      <= instr_i[11:7];
         r_e_illegal <= ~w_legal;
      end else if (w_transfer) begin
         r_e_valid   <= 1'b0;
      end
   end

   // Writeback register: capture ALU output on transfer, empty on drain without refill.
   // Illegal ops report result 0 / zero 1 regardless of the ALU's 111 behaviour.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_w_valid   <= 1'b0;
         r_w_result  <= '0;
         r_w_zero    <= 1'b0;
         r_w_rd      <= 5'd0;
         r_w_illegal <= 1'b0;
      end else if (w_transfer) begin
         r_w_valid   <= 1'b1;
         r_w_result  <= r_e_illegal ? '0 : alu_result_i;
         r_w_zero    <= r_e_illegal ? 1'b1 : alu_zero_i;
         r_w_rd      <= r_e_rd;
         r_w_illegal <= r_e_illegal;
      end else if (r_w_valid && out_ready_i) begin
         r_w_valid   <= 1'b0;
      end
   end

   assign alu_a_o       = r_e_a;
   assign alu_b_o       = r_e_b;
   assign alu_control_o = r_e_ctrl;

   assign out_valid_o   = r_w_valid;
   assign out_result_o  = r_w_result;
   assign out_zero_o    = r_w_zero;
   assign out_rd_o      = r_w_rd;
   assign out_illegal_o = r_w_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus a randomized
// valid/ready run scored against an instruction-level reference model.
module tb_alu_issue_stage;

   localparam int unsigned XLen = 32;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [31:0]     instr_i;
   logic [XLen-1:0] rs1_data_i;
   logic [XLen-1:0] rs2_data_i;
   logic [XLen-1:0] alu_a_o;
   logic [XLen-1:0] alu_b_o;
   logic [2:0]      alu_control_o;
   logic [XLen-1:0] alu_result_i;
   logic            alu_zero_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLen-1:0] out_result_o;
   logic            out_zero_o;
   logic [4:0]      out_rd_o;
   logic            out_illegal_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic [4:0]  rd;
      logic        illegal;
   } exp_t;

   exp_t q[$];

   alu_issue_stage #(.XLen(XLen)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .instr_i       (instr_i),
      .rs1_data_i    (rs1_data_i),
      .rs2_data_i    (rs2_data_i),
      .alu_a_o       (alu_a_o),
      .alu_b_o       (alu_b_o),
      .alu_control_o (alu_control_o),
      .alu_result_i  (alu_result_i),
      .alu_zero_i    (alu_zero_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_result_o  (out_result_o),
      .out_zero_o    (out_zero_o),
      .out_rd_o      (out_rd_o),
      .out_illegal_o (out_illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // Combinational ALU that the stage drives
   always_comb begin
      alu_result_i = '0;
      case (alu_control_o)
         3'b000:  alu_result_i = alu_a_o + alu_b_o;
         3'b001:  alu_result_i = alu_a_o - alu_b_o;
         3'b010:  alu_result_i = alu_a_o & alu_b_o;
         3'b011:  alu_result_i = alu_a_o | alu_b_o;
         3'b101:  alu_result_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
         default: alu_result_i = '0;
      endcase
      alu_zero_i = (alu_result_i == '0);
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {imm, 5'd1, f3, rd, 7'b0010011};
   endfunction

   // Instruction-level reference: what the writeback side must report.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t r;
      logic [31:0] opb;
      logic ok;
      r = '0;
      opb = '0;
      ok = 1'b1;
      r.rd = ins[11:7];
      if (ins[6:0] == 7'b0110011) opb = b;
      else if (ins[6:0] == 7'b0010011) opb = {{20{ins[31]}}, ins[31:20]};
      else ok = 1'b0;
      if (ok) begin
         case (ins[14:12])
            3'b000:  r.result = (ins[6:0] == 7'b0110011 && ins[30]) ? a - opb : a + opb;
            3'b010:  r.result = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            3'b110:  r.result = a | opb;
            3'b111:  r.result = a & opb;
            default: ok = 1'b0;
         endcase
      end
      if (!ok) r.result = '0;
      r.illegal = ~ok;
      r.zero = (r.result == '0);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b);
      in_valid_i = v;
      instr_i    = ins;
      rs1_data_i = a;
      rs2_data_i = b;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      out_ready_i = 1'b1;
      #12;
      rst_ni = 1'b1;
      tick();
      checks++;
      if ({in_ready_o, out_valid_o, out_result_o, out_zero_o, out_rd_o, out_illegal_o}
          !== {1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b vld=%b res=%h z=%b rd=%0d ill=%b want 1 0 0 0 0 0",
                  in_ready_o, out_valid_o, out_result_o, out_zero_o, out_rd_o, out_illegal_o);
      end
      checks++;
      if ({alu_a_o, alu_b_o, alu_control_o} !== {32'd0, 32'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_alu: a=%h b=%h ctl=%b want 0 0 000",
                  alu_a_o, alu_b_o, alu_control_o);
      end
   endtask

   task automatic test_add_sub();
      out_ready_i = 1'b1;
      drive(1'b1, enc_r(7'b0000000, 3'b000, 5'd3), 32'd5, 32'd7);
      tick();
      checks++;
      if ({alu_a_o, alu_b_o, alu_control_o} !== {32'd5, 32'd7, 3'b000}) begin
         errors++;
         $display("FAIL add_alu_in: a=%h b=%h ctl=%b want 5 7 000",
                  alu_a_o, alu_b_o, alu_control_o);
      end
      drive(1'b1, enc_r(7'b0100000, 3'b000, 5'd4), 32'd9, 32'd9);
      tick();
      checks++;
      if ({out_valid_o, out_result_o, out_zero_o, out_rd_o} !== {1'b1, 32'd12, 1'b0, 5'd3}) begin
         errors++;
         $display("FAIL add_out: vld=%b res=%0d z=%b rd=%0d want 1 12 0 3",
                  out_valid_o, out_result_o, out_zero_o, out_rd_o);
      end
      checks++;
      if (alu_control_o !== 3'b001) begin
         errors++;
         $display("FAIL sub_ctl: got %b want 001", alu_control_o);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      tick();
      checks++;
      if ({out_valid_o, out_result_o, out_zero_o, out_rd_o} !== {1'b1, 32'd0, 1'b1, 5'd4}) begin
         errors++;
         $display("FAIL sub_out: vld=%b res=%0d z=%b rd=%0d want 1 0 1 4",
                  out_valid_o, out_result_o, out_zero_o, out_rd_o);
      end
      tick();
      checks++;
      if (out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL add_sub_drain: vld=%b want 0", out_valid_o);
      end
   endtask

   task automatic test_imm_sext();
      out_ready_i = 1'b1;
      drive(1'b1, enc_i(12'hFFF, 3'b000, 5'd8), 32'd1, 32'h1234);
      tick();
      checks++;
      if (alu_b_o !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL addi_sext: alu_b=%h want ffffffff", alu_b_o);
      end
      drive(1'b1, enc_i(12'hFFF, 3'b010, 5'd9), 32'h8000_0000, 32'd0);
      tick();
      checks++;
      if ({out_result_o, out_zero_o, out_rd_o} !== {32'd0, 1'b1, 5'd8}) begin
         errors++;
         $display("FAIL addi_out: res=%h z=%b rd=%0d want 0 1 8",
                  out_result_o, out_zero_o, out_rd_o);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      tick();
      checks++;
      if ({out_result_o, out_zero_o, out_rd_o} !== {32'd1, 1'b0, 5'd9}) begin
         errors++;
         $display("FAIL slti_out: res=%h z=%b rd=%0d want 1 0 9",
                  out_result_o, out_zero_o, out_rd_o);
      end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready_i = 1'b0;
      drive(1'b1, enc_i(12'd1, 3'b000, 5'd5), 32'd10, 32'd0);
      tick();
      drive(1'b1, enc_i(12'd2, 3'b000, 5'd6), 32'd20, 32'd0);
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_second_ready: rdy=%b want 1", in_ready_o);
      end
      tick();
      drive(1'b1, enc_i(12'd3, 3'b000, 5'd7), 32'd30, 32'd0);
      #1;
      checks++;
      if (in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_third_blocked: rdy=%b want 0", in_ready_o);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({out_valid_o, out_result_o, out_rd_o, in_ready_o}
             !== {1'b1, 32'd11, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL bp_stall: vld=%b res=%0d rd=%0d rdy=%b want 1 11 5 0",
                     out_valid_o, out_result_o, out_rd_o, in_ready_o);
         end
      end
      out_ready_i = 1'b1;
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: rdy=%b want 1", in_ready_o);
      end
      tick();
      checks++;
      if ({out_valid_o, out_result_o, out_rd_o} !== {1'b1, 32'd22, 5'd6}) begin
         errors++;
         $display("FAIL bp_drain2: vld=%b res=%0d rd=%0d want 1 22 6",
                  out_valid_o, out_result_o, out_rd_o);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      tick();
      checks++;
      if ({out_valid_o, out_result_o, out_rd_o} !== {1'b1, 32'd33, 5'd7}) begin
         errors++;
         $display("FAIL bp_drain3: vld=%b res=%0d rd=%0d want 1 33 7",
                  out_valid_o, out_result_o, out_rd_o);
      end
      tick();
      checks++;
      if (out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: vld=%b want 0", out_valid_o);
      end
   endtask

   task automatic test_illegal();
      out_ready_i = 1'b1;
      drive(1'b1, {17'h1ABCD, 3'b010, 5'd10, 7'b0000011}, 32'd123, 32'd456);
      tick();
      checks++;
      if ({alu_control_o, alu_a_o, alu_b_o} !== {3'b111, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL load_alu_in: ctl=%b a=%h b=%h want 111 0 0",
                  alu_control_o, alu_a_o, alu_b_o);
      end
      drive(1'b1, enc_r(7'b0000000, 3'b001, 5'd11), 32'd3, 32'd4);
      tick();
      checks++;
      if ({out_valid_o, out_result_o, out_zero_o, out_rd_o, out_illegal_o}
          !== {1'b1, 32'd0, 1'b1, 5'd10, 1'b1}) begin
         errors++;
         $display("FAIL load_out: vld=%b res=%h z=%b rd=%0d ill=%b want 1 0 1 10 1",
                  out_valid_o, out_result_o, out_zero_o, out_rd_o, out_illegal_o);
      end
      checks++;
      if (alu_control_o !== 3'b111) begin
         errors++;
         $display("FAIL sll_ctl: got %b want 111", alu_control_o);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      tick();
      checks++;
      if ({out_result_o, out_zero_o, out_rd_o, out_illegal_o}
          !== {32'd0, 1'b1, 5'd11, 1'b1}) begin
         errors++;
         $display("FAIL sll_out: res=%h z=%b rd=%0d ill=%b want 0 1 11 1",
                  out_result_o, out_zero_o, out_rd_o, out_illegal_o);
      end
      tick();
   endtask

   task automatic test_reset_midstream();
      out_ready_i = 1'b0;
      drive(1'b1, enc_i(12'd5, 3'b000, 5'd12), 32'd1, 32'd0);
      tick();
      drive(1'b1, enc_i(12'd6, 3'b000, 5'd13), 32'd1, 32'd0);
      tick();
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({in_ready_o, out_valid_o, out_result_o, out_zero_o, out_rd_o, out_illegal_o,
           alu_a_o, alu_b_o, alu_control_o}
          !== {1'b1, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 3'b000}) begin
         errors++;
         $display("FAIL midreset: rdy=%b vld=%b res=%h rd=%0d a=%h b=%h ctl=%b want all idle",
                  in_ready_o, out_valid_o, out_result_o, out_rd_o, alu_a_o, alu_b_o,
                  alu_control_o);
      end
      drive(1'b0, 32'd0, 32'd0, 32'd0);
      out_ready_i = 1'b1;
      #2;
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: cycle %0d vld=%b want 0", i, out_valid_o);
         end
      end
   endtask

   task automatic test_random();
      localparam int NumInstr = 1000;
      int sent = 0;
      int cyc = 0;
      bit acc, drn;
      exp_t e;
      in_valid_i = 1'b0;
      while ((sent < NumInstr || q.size() != 0) && cyc < 20000) begin
         if (!in_valid_i && sent < NumInstr && $urandom_range(0, 3) != 0) begin
            instr_i = $urandom;
            case ($urandom_range(0, 9))
               0, 1, 2, 3: instr_i[6:0] = 7'b0110011;
               4, 5, 6, 7: instr_i[6:0] = 7'b0010011;
               default: ;
            endcase
            rs1_data_i = $urandom;
            rs2_data_i = ($urandom_range(0, 3) == 0) ? rs1_data_i : $urandom;
            in_valid_i = 1'b1;
         end
         out_ready_i = ($urandom_range(0, 2) != 0);
         #1;
         checks++;
         if (in_ready_o !== !(q.size() == 2 && !out_ready_i)) begin
            errors++;
            $display("FAIL rand_ready: cyc %0d rdy=%b inflight=%0d ordy=%b",
                     cyc, in_ready_o, q.size(), out_ready_i);
         end
         acc = in_valid_i && in_ready_o;
         drn = out_valid_o && out_ready_i;
         if (drn) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious: cyc %0d result %h with nothing in flight",
                        cyc, out_result_o);
            end else begin
               e = q.pop_front();
               if ({out_result_o, out_zero_o, out_rd_o, out_illegal_o} !== e) begin
                  errors++;
                  $display("FAIL rand_result: cyc %0d got res=%h z=%b rd=%0d ill=%b want res=%h z=%b rd=%0d ill=%b",
                           cyc, out_result_o, out_zero_o, out_rd_o, out_illegal_o,
                           e.result, e.zero, e.rd, e.illegal);
               end
            end
         end
         if (acc) begin
            q.push_back(model(instr_i, rs1_data_i, rs2_data_i));
            sent++;
         end
         tick();
         cyc++;
         if (acc) in_valid_i = 1'b0;
      end
      checks++;
      if (cyc >= 20000) begin
         errors++;
         $display("FAIL rand_timeout: sent %0d of %0d, %0d still in flight",
                  sent, NumInstr, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_imm_sext();
      test_backpressure();
      test_illegal();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue stage directly upstream of the ALU. It accepts RV32I register-register and register-immediate ALU instructions over a valid/ready handshake and decodes them into the ALU's 3-bit control code. It drives the ALU operand and control inputs from an internal execute register, then captures the ALU's result and zero flag into a writeback register with its own valid/ready handshake. It provides a two-stage, full-throughput pipeline around the purely combinational ALU.

## Interface
- XLen, 32, datapath width; immediates sign-extended to XLen
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  instruction and operands valid
- in_ready_o  output  1  stage can accept this cycle
- instr_i  input  32  raw instruction word
- rs1_data_i  input  XLen  rs1 register value
- rs2_data_i  input  XLen  rs2 register value (ignored for I-type)
- alu_a_o  output  XLen  ALU operand a (from execute register)
- alu_b_o  output  XLen  ALU operand b (rs2 or immediate)
- alu_control_o  output  3  ALU control code
- alu_result_i  input  XLen  ALU result (combinational from alu_*_o)
- alu_zero_i  input  1  ALU zero flag
- out_valid_o  output  1  writeback register holds a result
- out_ready_i  input  1  consumer accepts result this cycle
- out_result_o  output  XLen  registered result
- out_zero_o  output  1  registered zero flag
- out_rd_o  output  5  destination register (instr[11:7])
- out_illegal_o  output  1  instruction was not a supported ALU op

## Operation
- ALU control encoding: 000 add, 001 sub, 010 and, 011 or, 101 set-less-than (signed); 111 yields result 0 in the ALU.
- Decode by opcode instr[6:0]:
  - 0110011 (R-type): funct3 000 → add, or sub when instr[30]=1; 010 → slt; 110 → or; 111 → and.
  - 0010011 (I-type): funct3 000 → add (addi, instr[30] ignored); 010 → slt; 110 → or; 111 → and. Operand b = sign-extend(instr[31:20]).
- Any other opcode or funct3 is illegal:
  - The instruction is still accepted.
  - Control is forced to 111; operand a and operand b are forced to 0.
  - The illegal flag travels with the instruction.
  - Result: out_result_o=0, out_zero_o=1, out_illegal_o=1.
- R-type funct7 bits other than instr[30] are not checked.
- Execute register E holds e_valid, a, b, control, rd and illegal; alu_*_o are driven only from E, never from inputs.
- Writeback register W holds w_valid, result, zero, rd and illegal, all taken from E and the ALU inputs.
- Advance rules:
  - w_advance = ~w_valid | out_ready_i.
  - E→W transfer occurs when e_valid & w_advance.
  - in_ready_o = ~e_valid | w_advance (combinational path from out_ready_i).
  - Accept occurs when in_valid_i & in_ready_o; E loads the decoded fields.
  - If E transfers with no accept, e_valid clears.
  - If W drains (out_valid_o & out_ready_i) with no E transfer, w_valid clears.
- Simultaneous accept, transfer and drain in one cycle is legal: both stages update and nothing is lost or duplicated.
- Stall: when out_valid_o=1 and out_ready_i=0, W holds its outputs stable. E holds if full; in_ready_o=0 while both stages are full.
- Reset (rst_ni low, asynchronous, any time): e_valid=0, w_valid=0, and all data registers cleared.
  - Resulting outputs: in_ready_o=1, out_valid_o=0, out_result_o=0, out_zero_o=0, out_rd_o=0, out_illegal_o=0, alu_a_o=0, alu_b_o=0, alu_control_o=000.
  - An in-flight instruction is discarded.

## Timing
- Latency: an instruction accepted at edge N appears on alu_*_o after edge N and on out_*_o after edge N+1, giving 2 cycles to out_valid_o.
- Throughput: one instruction per cycle while out_ready_i=1.
- Buffering: maximum 2 instructions in flight; in_ready_o deasserts only when both E and W are full and out_ready_i=0.
- out_valid_o and out_* change only on clock edges or reset; they depend only on registers.
- alu_result_i and alu_zero_i are sampled at the edge that performs E→W; they must settle within the same cycle.

## Test plan
- Reset mid-stream: assert rst_ni=0 with both stages full → immediately out_valid_o=0, in_ready_o=1, all outputs 0; no stale result after release.
- add then sub back-to-back with out_ready_i=1:
  - add x3,x1,x2 with rs1=5, rs2=7 → out_result=12, zero=0, rd=3 two cycles after accept.
  - Next cycle, sub with rs1=rs2=9 → result 0, zero=1.
- Immediate sign extension: addi instr[31:20]=0xFFF with rs1=1 → alu_b_o=0xFFFFFFFF, result 0, zero=1. slti with imm=-1 and rs1=0x80000000 → result 1.
- Backpressure: hold out_ready_i=0 and feed 3 instructions.
  - First two accepted; in_ready_o=0 on the third, out_* stable.
  - Releasing out_ready_i drains all three in order, one per cycle, with none lost or duplicated.
- Illegal op: opcode 0000011 or R-type funct3=001 → accepted, alu_control_o=111, out_result=0, out_zero=1, out_illegal=1.
- Random valid/ready: random in_valid_i and out_ready_i toggling over 1000 instructions against a reference-model scoreboard → every result matches, order preserved.
